// File: rtl/pe_pkg.sv
// Shared definitions for the PE systolic array: row-link element format and
// drain-tracking sizing helpers.
package pe_pkg;

  localparam int unsigned PE_WIDTH = 4;

  // One element on a PE row link: operand, weight-slot tag and valid.
  typedef struct packed {
    logic [PE_WIDTH-1:0] data;
    logic                slot;
    logic                val;
  } pe_a_elem_t;

  // Cycles from accept until the last PE (ROWS-1, COLS-1) has consumed the vector.
  function automatic int unsigned drain_count(input int unsigned rows,
                                              input int unsigned cols);
    return rows + cols - 1;
  endfunction

  // Width of a per-slot drain counter.
  function automatic int unsigned cnt_width(input int unsigned rows,
                                            input int unsigned cols);
    return $clog2(rows + cols) + 1;
  endfunction

endpackage

// File: rtl/pe_skew_delay.sv
// Fixed-depth synchronous-reset shift register of row-link elements.
module pe_skew_delay
  import pe_pkg::*;
#(
  parameter int unsigned DEPTH  = 1,
  parameter type         elem_t = pe_a_elem_t
) (
  input  logic  clk,
  input  logic  rst_n,
  input  elem_t d_i,
  output elem_t q_o
);

  elem_t stage_q [DEPTH];
  elem_t stage_d [DEPTH];

  // Next-state: new element enters stage 0, every other stage takes its predecessor.
  always_comb begin
    stage_d[0] = d_i;
    for (int unsigned i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  // Stage registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pe_a_skew_feeder.sv
// A-operand skew feeder: turns one accepted vector per cycle into a row-skewed
// wavefront (row r lags row 0 by r cycles) and tracks per-slot drain status.
module pe_a_skew_feeder
  import pe_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned ROWS  = 4,
  parameter int unsigned COLS  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ROWS*WIDTH-1:0]   s_data,
  input  logic                    s_slot,
  input  logic                    s_val,
  output logic                    s_ready,
  input  logic [1:0]              wload_busy,
  output logic [ROWS*WIDTH-1:0]   ain,
  output logic [ROWS-1:0]         ain_slot,
  output logic [ROWS-1:0]         ain_val,
  output logic [1:0]              slot_busy
);

  localparam int unsigned DRAIN = drain_count(ROWS, COLS);
  localparam int unsigned CW    = cnt_width(ROWS, COLS);

  // Same layout as pe_a_elem_t, sized by this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             slot;
    logic             val;
  } elem_t;

  logic accept;

  // Ready depends combinationally on s_slot: a slot being reloaded blocks only itself.
  assign s_ready = !wload_busy[s_slot];
  assign accept  = s_val && s_ready;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    elem_t row_in;
    elem_t row_out;

    // Non-accept cycles inject a zero bubble so the array never stalls.
    always_comb begin
      row_in      = '0;
      row_in.data = accept ? s_data[r*WIDTH +: WIDTH] : '0;
      row_in.slot = accept ? s_slot : 1'b0;
      row_in.val  = accept;
    end

    pe_skew_delay #(
      .DEPTH  (r + 1),
      .elem_t (elem_t)
    ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (row_in),
      .q_o   (row_out)
    );

    assign ain[r*WIDTH +: WIDTH] = row_out.data;
    assign ain_slot[r]           = row_out.slot;
    assign ain_val[r]            = row_out.val;
  end

  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  // Drain counters: accept to a slot reloads it (load beats decrement), otherwise count down.
  always_comb begin
    for (int unsigned k = 0; k < 2; k++) begin
      cnt_d[k] = cnt_q[k];
      if (accept && (s_slot == 1'(k))) begin
        cnt_d[k] = CW'(DRAIN);
      end else if (cnt_q[k] != '0) begin
        cnt_d[k] = cnt_q[k] - 1'b1;
      end
    end
  end

  // Drain counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
    end
  end

  assign slot_busy[0] = (cnt_q[0] != '0);
  assign slot_busy[1] = (cnt_q[1] != '0);

endmodule

// File: tb/tb_pe_a_skew_feeder.sv
// Scoreboard bench for pe_a_skew_feeder: stimulus pushes per-row expected
// elements with due cycles; a negedge monitor pops and compares.
module tb_pe_a_skew_feeder;

  localparam int W     = 4;
  localparam int R     = 4;
  localparam int C     = 4;
  localparam int DRAIN = R + C - 1;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [R*W-1:0] s_data;
  logic           s_slot;
  logic           s_val;
  logic           s_ready;
  logic [1:0]     wload_busy;
  logic [R*W-1:0] ain;
  logic [R-1:0]   ain_slot;
  logic [R-1:0]   ain_val;
  logic [1:0]     slot_busy;

  pe_a_skew_feeder #(.WIDTH(W), .ROWS(R), .COLS(C)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_data     (s_data),
    .s_slot     (s_slot),
    .s_val      (s_val),
    .s_ready    (s_ready),
    .wload_busy (wload_busy),
    .ain        (ain),
    .ain_slot   (ain_slot),
    .ain_val    (ain_val),
    .slot_busy  (slot_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic         slot;
    int           due;
  } exp_t;

  exp_t rowq [R][$];
  int   busy_from  [2];
  int   busy_until [2];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Drive one cycle of inputs and update the reference model for that cycle.
  task automatic step(input bit rst, input bit val, input bit slot,
                      input logic [R*W-1:0] data, input logic [1:0] wb);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n      = rst;
    s_val      = val;
    s_slot     = slot;
    s_data     = data;
    wload_busy = wb;
    if (!rst) begin
      for (int r = 0; r < R; r++)
        while (rowq[r].size() > 0 && rowq[r][$].due > cyc) void'(rowq[r].pop_back());
      for (int k = 0; k < 2; k++)
        if (busy_until[k] > cyc) busy_until[k] = cyc;
    end else if (val && !wb[slot]) begin
      for (int r = 0; r < R; r++) begin
        e.data = data[r*W +: W];
        e.slot = slot;
        e.due  = cyc + 1 + r;
        rowq[r].push_back(e);
      end
      if (busy_until[slot] < cyc) busy_from[slot] = cyc + 1;
      busy_until[slot] = cyc + DRAIN;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, '0, 2'b00);
  endtask

  task automatic send(input bit slot, input logic [R*W-1:0] data);
    step(1'b1, 1'b1, slot, data, 2'b00);
  endtask

  // Monitor: compare every row and the status outputs each cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      for (int r = 0; r < R; r++) begin
        logic [W-1:0] d;
        d = ain[r*W +: W];
        checks++;
        while (rowq[r].size() > 0 && rowq[r][0].due < cyc) begin
          $display("FAIL row%0d_missing cyc=%0d got=none exp=due%0d", r, cyc, rowq[r][0].due);
          errors++;
          void'(rowq[r].pop_front());
        end
        if (ain_val[r]) begin
          exp_t e;
          checks++;
          if (rowq[r].size() == 0) begin
            $display("FAIL row%0d_unexpected cyc=%0d got=%0h exp=none", r, cyc, d);
            errors++;
          end else begin
            e = rowq[r].pop_front();
            if (e.due != cyc || e.data != d || e.slot != ain_slot[r]) begin
              $display("FAIL row%0d_elem cyc=%0d got=%0h/s%0d exp=%0h/s%0d@%0d",
                       r, cyc, d, ain_slot[r], e.data, e.slot, e.due);
              errors++;
            end
          end
        end else begin
          checks++;
          if (d != '0 || ain_slot[r] != 1'b0) begin
            $display("FAIL row%0d_bubble cyc=%0d got=%0h/s%0d exp=0/s0", r, cyc, d, ain_slot[r]);
            errors++;
          end
        end
      end
      for (int k = 0; k < 2; k++) begin
        bit eb;
        eb = (cyc >= busy_from[k]) && (cyc <= busy_until[k]);
        checks++;
        if (slot_busy[k] !== eb) begin
          $display("FAIL slot_busy%0d cyc=%0d got=%b exp=%b", k, cyc, slot_busy[k], eb);
          errors++;
        end
      end
      begin
        logic er;
        er = (s_slot == 1'b0) ? !wload_busy[0] : !wload_busy[1];
        checks++;
        if (s_ready !== er) begin
          $display("FAIL s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, er);
          errors++;
        end
      end
    end
  end

  initial begin
    logic [R*W-1:0] v;
    for (int k = 0; k < 2; k++) begin
      busy_from[k]  = 1;
      busy_until[k] = 0;
    end
    rst_n      = 1'b0;
    s_val      = 1'b1;
    s_slot     = 1'b1;
    s_data     = 16'hBEEF;
    wload_busy = 2'b10;

    // Reset with garbage inputs for two cycles.
    step(1'b0, 1'b1, 1'b1, 16'hA5C3, 2'b10);
    mon_en = 1'b1;
    step(1'b0, 1'b1, 1'b0, 16'h5A3C, 2'b01);
    idle(1);

    // Single vector {3,2,1,0} on slot 1.
    v = {4'd3, 4'd2, 4'd1, 4'd0};
    send(1'b1, v);
    idle(10);

    // Three back-to-back vectors, slots 0,1,0.
    send(1'b0, 16'h1234);
    send(1'b1, 16'h5678);
    send(1'b0, 16'h9ABC);
    idle(12);

    // Backpressure on slot 0, then same-cycle switch to slot 1.
    step(1'b1, 1'b1, 1'b0, 16'hDEAD, 2'b01);
    step(1'b1, 1'b1, 1'b1, 16'hCAFE, 2'b01);
    step(1'b1, 1'b1, 1'b1, 16'hF00D, 2'b11);
    idle(10);

    // Re-arm slot 0 five cycles after the first accept.
    send(1'b0, 16'h1111);
    idle(4);
    send(1'b0, 16'h2222);
    idle(14);

    // Mid-stream reset two cycles after an accept.
    send(1'b1, 16'h7777);
    idle(1);
    step(1'b0, 1'b1, 1'b0, 16'h8888, 2'b00);
    idle(10);

    // Randomized traffic with occasional resets and loader activity.
    for (int i = 0; i < 400; i++) begin
      bit         rb, vb, sb;
      logic [1:0] wb;
      rb = ($urandom_range(0, 59) != 0);
      vb = ($urandom_range(0, 9) < 7);
      sb = 1'($urandom_range(0, 1));
      wb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      step(rb, vb, sb, 16'($urandom), wb);
    end
    idle(15);

    for (int r = 0; r < R; r++) begin
      checks++;
      if (rowq[r].size() != 0) begin
        $display("FAIL row%0d_drain got=%0d exp=0 pending", r, rowq[r].size());
        errors++;
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
